// File: rtl/mcdt_pkt_fmt.sv
// mcdt_pkt_fmt: packet formatter downstream of the mcdt arbiter.
// Buffers the arbitrated stream per channel and emits header+payload packets.
//
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   mcdt_data_i/val_i/id_i   arbitrated input word, valid, channel (3 = illegal)
//   fmt_data_o/valid_o   packet word out, valid
//   fmt_ready_i          downstream accepts word when valid && ready
//   fmt_sop_o/eop_o      header marker / last payload word marker
//   fmt_ovf_o            sticky per-channel overflow flags
//   fmt_ovf_clr_i        clears all overflow flags (a new drop wins)
//   fmt_idle_o           FSM idle and all channel FIFOs empty
module mcdt_pkt_fmt #(
    parameter int PKT_LEN    = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] mcdt_data_i,
    input  logic        mcdt_val_i,
    input  logic [1:0]  mcdt_id_i,
    output logic [31:0] fmt_data_o,
    output logic        fmt_valid_o,
    input  logic        fmt_ready_i,
    output logic        fmt_sop_o,
    output logic        fmt_eop_o,
    output logic [2:0]  fmt_ovf_o,
    input  logic        fmt_ovf_clr_i,
    output logic        fmt_idle_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LEN_C   = CW'(PKT_LEN);
    localparam logic [CW-1:0] LAST_C  = CW'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        BODY
    } state_t;

    state_t state_q, state_d;

    logic [31:0]   mem [3][FIFO_DEPTH];
    logic [AW-1:0] wr_ptr [3];
    logic [AW-1:0] rd_ptr [3];
    logic [CW-1:0] cnt [3];

    logic [2:0]    push;
    logic [2:0]    pop;
    logic [2:0]    drop;
    logic [2:0]    elig;

    logic [1:0]    sel_q;
    logic [1:0]    rr_last_q;
    logic [CW-1:0] beat_q;
    logic [7:0]    seq_q [3];
    logic [2:0]    ovf_q;

    logic [1:0]    pick;
    logic          pick_vld;
    logic [1:0]    cand1;
    logic [1:0]    cand2;
    logic          last_beat;

    function automatic logic [1:0] nxt(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Full check is against the pre-pop count, so a push to a full FIFO
    // is dropped even when the same FIFO is being popped this cycle.
    always_comb begin
        push = '0;
        drop = '0;
        for (int c = 0; c < 3; c++) begin
            if (mcdt_val_i && mcdt_id_i == 2'(c)) begin
                if (cnt[c] < DEPTH_C) begin
                    push[c] = 1'b1;
                end else begin
                    drop[c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        pop  = '0;
        elig = '0;
        for (int c = 0; c < 3; c++) begin
            pop[c]  = (state_q == BODY) && fmt_ready_i && (sel_q == 2'(c));
            elig[c] = (cnt[c] >= LEN_C);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < 3; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                cnt[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (push[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + AW'(1);
                end
                if (pop[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + AW'(1);
                end
                case ({push[c], pop[c]})
                    2'b10:   cnt[c] <= cnt[c] + CW'(1);
                    2'b01:   cnt[c] <= cnt[c] - CW'(1);
                    default: cnt[c] <= cnt[c];
                endcase
            end
        end
    end

    // Storage needs no reset: the pointers alone define FIFO contents.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < 3; c++) begin
            if (push[c]) begin
                mem[c][wr_ptr[c]] <= mcdt_data_i;
            end
        end
    end

    // Round robin: search starts at the channel after the last one served.
    always_comb begin
        cand1    = nxt(rr_last_q);
        cand2    = nxt(cand1);
        pick_vld = |elig;
        pick     = rr_last_q;
        if (elig[cand1]) begin
            pick = cand1;
        end else if (elig[cand2]) begin
            pick = cand2;
        end
    end

    assign last_beat = (beat_q == LAST_C);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fmt_valid_o = 1'b0;
        fmt_sop_o   = 1'b0;
        fmt_eop_o   = 1'b0;
        fmt_data_o  = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = HEAD;
                end
            end
            HEAD: begin
                fmt_valid_o = 1'b1;
                fmt_sop_o   = 1'b1;
                fmt_data_o  = {8'hA5, 6'b0, sel_q,
                               8'(PKT_LEN), seq_q[sel_q]};
                if (fmt_ready_i) begin
                    state_d = BODY;
                end
            end
            BODY: begin
                fmt_valid_o = 1'b1;
                fmt_eop_o   = last_beat;
                fmt_data_o  = mem[sel_q][rd_ptr[sel_q]];
                if (fmt_ready_i && last_beat) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sel_q     <= '0;
            rr_last_q <= 2'd2;
            beat_q    <= '0;
            for (int c = 0; c < 3; c++) begin
                seq_q[c] <= '0;
            end
        end else begin
            if (state_q == IDLE && pick_vld) begin
                sel_q <= pick;
            end
            if (state_q == HEAD && fmt_ready_i) begin
                beat_q <= '0;
            end
            if (state_q == BODY && fmt_ready_i) begin
                beat_q <= beat_q + CW'(1);
                if (last_beat) begin
                    seq_q[sel_q] <= seq_q[sel_q] + 8'd1;
                    rr_last_q    <= sel_q;
                end
            end
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= (ovf_q & ~{3{fmt_ovf_clr_i}}) | drop;
        end
    end

    assign fmt_ovf_o  = ovf_q;
    assign fmt_idle_o = (state_q == IDLE) && (cnt[0] == '0) &&
                        (cnt[1] == '0) && (cnt[2] == '0);

endmodule

// File: tb/tb_mcdt_pkt_fmt.sv
// tb_mcdt_pkt_fmt: randomized self-checking bench for mcdt_pkt_fmt.
// A queue-based packet model predicts every output word.
module tb_mcdt_pkt_fmt;

    localparam int LEN   = 4;
    localparam int DEPTH = 16;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [31:0] mcdt_data_i = '0;
    logic        mcdt_val_i = 1'b0;
    logic [1:0]  mcdt_id_i = '0;
    logic [31:0] fmt_data_o;
    logic        fmt_valid_o;
    logic        fmt_ready_i = 1'b0;
    logic        fmt_sop_o;
    logic        fmt_eop_o;
    logic [2:0]  fmt_ovf_o;
    logic        fmt_ovf_clr_i = 1'b0;
    logic        fmt_idle_o;

    mcdt_pkt_fmt #(.PKT_LEN(LEN), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .mcdt_data_i   (mcdt_data_i),
        .mcdt_val_i    (mcdt_val_i),
        .mcdt_id_i     (mcdt_id_i),
        .fmt_data_o    (fmt_data_o),
        .fmt_valid_o   (fmt_valid_o),
        .fmt_ready_i   (fmt_ready_i),
        .fmt_sop_o     (fmt_sop_o),
        .fmt_eop_o     (fmt_eop_o),
        .fmt_ovf_o     (fmt_ovf_o),
        .fmt_ovf_clr_i (fmt_ovf_clr_i),
        .fmt_idle_o    (fmt_idle_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_fail = 0;

    // {sop, eop, data}
    logic [33:0] obs[$];
    logic [33:0] exp_q[$];

    logic [31:0] m0[$];
    logic [31:0] m1[$];
    logic [31:0] m2[$];
    logic [7:0]  mseq [3];
    int          mrr;
    logic [2:0]  movf;

    always @(negedge clk_i) begin
        if (rstn_i && fmt_valid_o && fmt_ready_i) begin
            obs.push_back({fmt_sop_o, fmt_eop_o, fmt_data_o});
        end
    end

    function automatic int msize(input int ch);
        case (ch)
            0:       return m0.size();
            1:       return m1.size();
            default: return m2.size();
        endcase
    endfunction

    function automatic logic [31:0] mpop(input int ch);
        case (ch)
            0:       return m0.pop_front();
            1:       return m1.pop_front();
            default: return m2.pop_front();
        endcase
    endfunction

    function automatic void model_reset();
        m0.delete();
        m1.delete();
        m2.delete();
        for (int c = 0; c < 3; c++) mseq[c] = 8'd0;
        mrr  = 2;
        movf = 3'b000;
    endfunction

    function automatic void model_push(input int ch, input logic [31:0] d);
        if (ch > 2) return;
        if (msize(ch) >= DEPTH) begin
            movf[ch] = 1'b1;
            return;
        end
        case (ch)
            0:       m0.push_back(d);
            1:       m1.push_back(d);
            default: m2.push_back(d);
        endcase
    endfunction

    // Emit every complete packet the buffered words allow, in
    // round-robin order starting after the last channel served.
    function automatic void model_drain();
        int pick;
        forever begin
            pick = -1;
            for (int k = 1; k <= 3; k++) begin
                if (pick < 0 && msize((mrr + k) % 3) >= LEN) begin
                    pick = (mrr + k) % 3;
                end
            end
            if (pick < 0) break;
            exp_q.push_back({2'b10, 8'hA5, 6'b0, 2'(pick),
                             8'(LEN), mseq[pick]});
            for (int b = 0; b < LEN; b++) begin
                exp_q.push_back({1'b0, (b == LEN - 1), mpop(pick)});
            end
            mseq[pick] = mseq[pick] + 8'd1;
            mrr = pick;
        end
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input int ch, input logic [31:0] d);
        mcdt_val_i  = 1'b1;
        mcdt_id_i   = 2'(ch);
        mcdt_data_i = d;
        model_push(ch, d);
        tick();
        mcdt_val_i  = 1'b0;
    endtask

    task automatic apply_reset();
        rstn_i        = 1'b0;
        mcdt_val_i    = 1'b0;
        fmt_ready_i   = 1'b0;
        fmt_ovf_clr_i = 1'b0;
        repeat (2) tick();
        rstn_i = 1'b1;
        tick();
        model_reset();
        obs.delete();
        exp_q.delete();
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        int i;
        i = 0;
        while (obs.size() < n && i < budget) begin
            tick();
            i++;
        end
        ok = (obs.size() >= n);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        tick();
        n_chk++;
        if (fmt_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset valid: got %b need 0", fmt_valid_o);
        end
        n_chk++;
        if ({fmt_sop_o, fmt_eop_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset sop/eop: got %b%b need 00", fmt_sop_o, fmt_eop_o);
        end
        n_chk++;
        if (fmt_data_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset data: got %h need 0", fmt_data_o);
        end
        n_chk++;
        if (fmt_ovf_o !== 3'b000) begin
            n_fail++;
            $display("FAIL reset ovf: got %b need 000", fmt_ovf_o);
        end
        n_chk++;
        if (fmt_idle_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset idle: got %b need 1", fmt_idle_o);
        end
        apply_reset();
    endtask

    task automatic test_single();
        bit ok;
        apply_reset();
        fmt_ready_i = 1'b1;
        for (int i = 0; i < LEN; i++) wr(0, 32'h00C0_0000 + 32'(i));
        n_chk++;
        if (fmt_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single latency early: valid %b need 0", fmt_valid_o);
        end
        tick();
        n_chk++;
        if ({fmt_valid_o, fmt_sop_o} !== 2'b11) begin
            n_fail++;
            $display("FAIL single latency hdr: valid/sop %b%b need 11",
                     fmt_valid_o, fmt_sop_o);
        end
        model_drain();
        wait_obs(exp_q.size(), 50, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single timeout: got %0d words need %0d",
                     obs.size(), exp_q.size());
        end
        n_chk++;
        if (obs.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL single count: got %0d need %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_chk++;
            if (obs[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL single word %0d: got %h need %h", i, obs[i], exp_q[i]);
            end
        end
        if (obs.size() > 0) begin
            n_chk++;
            if (obs[0] !== {2'b10, 32'hA500_0400}) begin
                n_fail++;
                $display("FAIL single hdr const: got %h need A500_0400 sop", obs[0]);
            end
        end
        n_chk++;
        if (fmt_idle_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single idle: got %b need 1", fmt_idle_o);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [31:0] hdr_c [3];
        hdr_c[0] = 32'hA500_0400;
        hdr_c[1] = 32'hA501_0400;
        hdr_c[2] = 32'hA502_0400;
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            obs.delete();
            exp_q.delete();
            fmt_ready_i = 1'b0;
            for (int c = 0; c < 3; c++) begin
                for (int i = 0; i < LEN; i++) wr(c, $urandom);
            end
            repeat (3) tick();
            fmt_ready_i = 1'b1;
            model_drain();
            wait_obs(exp_q.size(), 100, ok);
            n_chk++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rr timeout: got %0d words need %0d",
                         obs.size(), exp_q.size());
            end
            n_chk++;
            if (obs.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL rr count: got %0d need %0d", obs.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
                n_chk++;
                if (obs[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rr round %0d word %0d: got %h need %h",
                             r, i, obs[i], exp_q[i]);
                end
            end
            for (int c = 0; c < 3; c++) begin
                if (obs.size() > c * (LEN + 1)) begin
                    n_chk++;
                    if (obs[c*(LEN+1)][31:0] !== (hdr_c[c] | 32'(r))) begin
                        n_fail++;
                        $display("FAIL rr hdr const ch%0d: got %h need %h", c,
                                 obs[c*(LEN+1)][31:0], hdr_c[c] | 32'(r));
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit stall;
        logic [33:0] held;
        int cyc;
        bit pat [7];
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 2 * LEN; i++) wr(1, $urandom);
        model_drain();
        stall = 1'b0;
        held  = '0;
        cyc   = 0;
        while (obs.size() < exp_q.size() && cyc < 300) begin
            fmt_ready_i = (cyc < 7) ? pat[cyc] : 1'($urandom_range(0, 1));
            @(negedge clk_i);
            if (stall) begin
                n_chk++;
                if (!fmt_valid_o ||
                    {fmt_sop_o, fmt_eop_o, fmt_data_o} !== held) begin
                    n_fail++;
                    $display("FAIL bp hold cyc %0d: got v=%b %h need v=1 %h",
                             cyc, fmt_valid_o,
                             {fmt_sop_o, fmt_eop_o, fmt_data_o}, held);
                end
            end
            stall = fmt_valid_o && !fmt_ready_i;
            held  = {fmt_sop_o, fmt_eop_o, fmt_data_o};
            tick();
            cyc++;
        end
        fmt_ready_i = 1'b1;
        repeat (3) tick();
        n_chk++;
        if (obs.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL bp count: got %0d need %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_chk++;
            if (obs[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL bp word %0d: got %h need %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int cyc;
        for (int it = 0; it < 3; it++) begin
            apply_reset();
            for (int c = 0; c < 3; c++) begin
                int n;
                n = $urandom_range(LEN, 14);
                for (int i = 0; i < n; i++) begin
                    if ($urandom_range(0, 3) == 0) wr(3, $urandom);
                    wr(c, $urandom);
                end
            end
            model_drain();
            cyc = 0;
            while (obs.size() < exp_q.size() && cyc < 400) begin
                fmt_ready_i = 1'($urandom_range(0, 1));
                tick();
                cyc++;
            end
            fmt_ready_i = 1'b1;
            wait_obs(exp_q.size(), 20, ok);
            n_chk++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rand timeout it %0d: got %0d need %0d",
                         it, obs.size(), exp_q.size());
            end
            n_chk++;
            if (obs.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL rand count it %0d: got %0d need %0d",
                         it, obs.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
                n_chk++;
                if (obs[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand it %0d word %0d: got %h need %h",
                             it, i, obs[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        apply_reset();
        for (int i = 0; i < DEPTH + 1; i++) wr(1, $urandom);
        n_chk++;
        if (fmt_ovf_o !== movf || movf !== 3'b010) begin
            n_fail++;
            $display("FAIL ovf set: got %b need 010", fmt_ovf_o);
        end
        fmt_ovf_clr_i = 1'b1;
        movf = 3'b000;
        tick();
        fmt_ovf_clr_i = 1'b0;
        n_chk++;
        if (fmt_ovf_o !== movf) begin
            n_fail++;
            $display("FAIL ovf clr: got %b need %b", fmt_ovf_o, movf);
        end
        fmt_ovf_clr_i = 1'b1;
        movf = 3'b000;
        wr(1, $urandom);
        fmt_ovf_clr_i = 1'b0;
        n_chk++;
        if (fmt_ovf_o !== movf || movf !== 3'b010) begin
            n_fail++;
            $display("FAIL ovf set-over-clr: got %b need 010", fmt_ovf_o);
        end
        fmt_ovf_clr_i = 1'b1;
        movf = 3'b000;
        tick();
        fmt_ovf_clr_i = 1'b0;
        fmt_ready_i = 1'b1;
        model_drain();
        wait_obs(exp_q.size(), 150, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ovf timeout: got %0d need %0d", obs.size(), exp_q.size());
        end
        n_chk++;
        if (obs.size() !== exp_q.size() || exp_q.size() !== 4 * (LEN + 1)) begin
            n_fail++;
            $display("FAIL ovf stored: got %0d words need %0d",
                     obs.size(), 4 * (LEN + 1));
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_chk++;
            if (obs[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL ovf word %0d: got %h need %h", i, obs[i], exp_q[i]);
            end
        end
        n_chk++;
        if (fmt_idle_o !== 1'b1 || fmt_ovf_o !== 3'b000) begin
            n_fail++;
            $display("FAIL ovf end: idle %b ovf %b need 1 000", fmt_idle_o, fmt_ovf_o);
        end
    endtask

    task automatic test_seq_wrap();
        bit ok;
        logic [7:0] seq_at [257];
        apply_reset();
        fmt_ready_i = 1'b1;
        wr(3, $urandom);
        for (int i = 0; i < LEN; i++) begin
            wr(2, $urandom);
            wr(3, $urandom);
        end
        n_chk++;
        if (fmt_ovf_o !== 3'b000) begin
            n_fail++;
            $display("FAIL id3 ovf: got %b need 000", fmt_ovf_o);
        end
        for (int p = 0; p < 257; p++) begin
            if (p > 0) begin
                for (int i = 0; i < LEN; i++) wr(2, $urandom);
            end
            model_drain();
            wait_obs(exp_q.size(), 40, ok);
            n_chk++;
            if (!ok || obs.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL wrap pkt %0d count: got %0d need %0d",
                         p, obs.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
                n_chk++;
                if (obs[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL wrap pkt %0d word %0d: got %h need %h",
                             p, i, obs[i], exp_q[i]);
                end
            end
            seq_at[p] = (obs.size() > 0) ? obs[0][7:0] : 8'hXX;
            obs.delete();
            exp_q.delete();
        end
        n_chk++;
        if (seq_at[255] !== 8'hFF) begin
            n_fail++;
            $display("FAIL wrap seq 255: got %h need FF", seq_at[255]);
        end
        n_chk++;
        if (seq_at[256] !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap seq 256: got %h need 00", seq_at[256]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset();
        for (int i = 0; i < LEN; i++) wr(0, $urandom);
        for (int i = 0; i < 3; i++) wr(1, $urandom);
        fmt_ready_i = 1'b1;
        wait_obs(3, 40, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstmid timeout: got %0d need 3", obs.size());
        end
        obs.delete();
        for (int i = 0; i < LEN; i++) wr(0, $urandom);
        fmt_ready_i = 1'b0;
        repeat (3) tick();
        fmt_ready_i = 1'b1;
        while (obs.size() < 3) tick();
        fmt_ready_i = 1'b0;
        n_chk++;
        if ({fmt_valid_o, fmt_sop_o, fmt_eop_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL rstmid pre: v/sop/eop %b%b%b need 100",
                     fmt_valid_o, fmt_sop_o, fmt_eop_o);
        end
        #2;
        rstn_i = 1'b0;
        #1;
        n_chk++;
        if ({fmt_valid_o, fmt_sop_o, fmt_eop_o, fmt_data_o} !== 35'h0) begin
            n_fail++;
            $display("FAIL rstmid outputs: v=%b sop=%b eop=%b data=%h need 0",
                     fmt_valid_o, fmt_sop_o, fmt_eop_o, fmt_data_o);
        end
        n_chk++;
        if (fmt_idle_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid idle: got %b need 1", fmt_idle_o);
        end
        tick();
        rstn_i = 1'b1;
        tick();
        model_reset();
        obs.delete();
        exp_q.delete();
        fmt_ready_i = 1'b1;
        for (int i = 0; i < LEN; i++) wr(0, $urandom);
        model_drain();
        wait_obs(exp_q.size(), 40, ok);
        n_chk++;
        if (!ok || obs.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL rstmid count: got %0d need %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            n_chk++;
            if (obs[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rstmid word %0d: got %h need %h", i, obs[i], exp_q[i]);
            end
        end
        n_chk++;
        if (fmt_idle_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid flushed: idle %b need 1", fmt_idle_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_random();
        test_overflow();
        test_seq_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
